// File: rtl/perceptron_trainer_if.sv
// Perceptron drive bus: sample features and label out, decision back in.
interface perceptron_trainer_if;
    logic [3:0] p_in1;
    logic [3:0] p_in2;
    logic [6:0] p_in3;
    logic       p_desired;
    logic       p_out;

    modport master (
        output p_in1, p_in2, p_in3, p_desired,
        input  p_out
    );

    modport slave (
        input  p_in1, p_in2, p_in3, p_desired,
        output p_out
    );
endinterface

// File: rtl/perceptron_trainer.sv
// Training sequencer: replays a labelled sample table into a perceptron
// and counts misclassifications per epoch until converged or out of epochs.
module perceptron_trainer #(
    parameter int NUM_SAMPLES = 8,
    parameter int ADDR_W      = 3,
    parameter int MAX_EPOCHS  = 16,
    parameter int EPOCH_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [3:0]         load_in1,
    input  logic [3:0]         load_in2,
    input  logic [6:0]         load_in3,
    input  logic               load_desired,
    input  logic [ADDR_W:0]    num_samples,
    input  logic               start,
    perceptron_trainer_if.master pbus,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epoch_count,
    output logic [ADDR_W:0]    err_count
);

    typedef enum logic [2:0] {
        IDLE,
        PRESENT,
        CHECK,
        EPOCH_END,
        FINISH
    } state_t;

    localparam logic [ADDR_W:0]    NS   = (ADDR_W+1)'(NUM_SAMPLES);
    localparam logic [EPOCH_W-1:0] MAXE = EPOCH_W'(MAX_EPOCHS);

    // Entry layout: {in1[3:0], in2[3:0], in3[6:0], desired}
    logic [15:0]        smp_q [NUM_SAMPLES];
    state_t             state;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  n_last;
    logic [ADDR_W:0]    err_acc;
    logic [15:0]        p_q;

    logic               wr;
    logic [15:0]        wr_data;
    logic [15:0]        first;
    logic [15:0]        cur;
    logic [15:0]        nxt;
    logic [ADDR_W-1:0]  idx_inc;
    logic               mis;
    logic [ADDR_W:0]    err_inc;
    logic [ADDR_W:0]    ns_eff;
    logic [ADDR_W-1:0]  n_clamp;
    logic [EPOCH_W-1:0] ep_next;

    assign pbus.p_in1     = p_q[15:12];
    assign pbus.p_in2     = p_q[11:8];
    assign pbus.p_in3     = p_q[7:1];
    assign pbus.p_desired = p_q[0];

    always_comb begin
        wr      = load_en && !busy;
        wr_data = {load_in1, load_in2, load_in3, load_desired};
        // A write landing with start must be visible to the first sample.
        first   = (wr && load_addr == '0) ? wr_data : smp_q[0];
        cur     = smp_q[idx];
        idx_inc = idx + 1'b1;
        nxt     = smp_q[idx_inc];
        mis     = pbus.p_out != cur[0];
        err_inc = (err_acc == '1) ? err_acc : err_acc + (ADDR_W+1)'(mis);
        ns_eff  = (num_samples == '0 || num_samples > NS) ? NS : num_samples;
        n_clamp = ADDR_W'(ns_eff - 1'b1);
        ep_next = epoch_count + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SAMPLES; i++) smp_q[i] <= '0;
        end else if (wr) begin
            smp_q[load_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            n_last      <= '0;
            err_acc     <= '0;
            epoch_count <= '0;
            err_count   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            p_q         <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_last      <= n_clamp;
                        idx         <= '0;
                        err_acc     <= '0;
                        epoch_count <= '0;
                        converged   <= 1'b0;
                        busy        <= 1'b1;
                        p_q         <= first;
                        state       <= PRESENT;
                    end
                end
                PRESENT: state <= CHECK;
                CHECK: begin
                    err_acc <= err_inc;
                    if (idx == n_last) begin
                        p_q   <= '0;
                        state <= EPOCH_END;
                    end else begin
                        idx   <= idx_inc;
                        p_q   <= nxt;
                        state <= PRESENT;
                    end
                end
                EPOCH_END: begin
                    epoch_count <= ep_next;
                    err_count   <= err_acc;
                    if (err_acc == '0) begin
                        converged <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FINISH;
                    end else if (ep_next == MAXE) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        err_acc <= '0;
                        idx     <= '0;
                        p_q     <= smp_q[0];
                        state   <= PRESENT;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench: fixed-weight perceptron stand-in plus an epoch-level
// model predicting drive sequence, timing and final counters.
module tb_perceptron_trainer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_en = 1'b0;
    logic [2:0] load_addr = '0;
    logic [3:0] load_in1 = '0;
    logic [3:0] load_in2 = '0;
    logic [6:0] load_in3 = '0;
    logic       load_desired = 1'b0;
    logic [3:0] num_samples = '0;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic       converged;
    logic [7:0] epoch_count;
    logic [3:0] err_count;

    logic       tie1 = 1'b0;
    logic       p_out_r = 1'b0;
    logic [15:0] tab [8];

    int checks = 0;
    int failures = 0;

    perceptron_trainer_if pbus ();

    perceptron_trainer dut (
        .clk          (clk),
        .reset        (reset),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_in1     (load_in1),
        .load_in2     (load_in2),
        .load_in3     (load_in3),
        .load_desired (load_desired),
        .num_samples  (num_samples),
        .start        (start),
        .pbus         (pbus.master),
        .busy         (busy),
        .done         (done),
        .converged    (converged),
        .epoch_count  (epoch_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    function automatic logic pred(input logic [15:0] e);
        int s;
        s = 10 * int'(e[15:12]) + 15 * int'(e[11:8]) + 30 * int'(e[7:1]);
        return s >= 200;
    endfunction

    // Perceptron stand-in: fixed weights (10,15,30), threshold 200, registered.
    always @(posedge clk)
        p_out_r <= tie1 ? 1'b1 :
            pred({pbus.p_in1, pbus.p_in2, pbus.p_in3, pbus.p_desired});
    assign pbus.p_out = p_out_r;

    function automatic logic [15:0] ent(input int a, b, c, d);
        return {4'(a), 4'(b), 7'(c), 1'(d)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic drive_load(input bit en, input int a, input logic [15:0] d);
        load_en      = en;
        load_addr    = 3'(a);
        load_in1     = d[15:12];
        load_in2     = d[11:8];
        load_in3     = d[7:1];
        load_desired = d[0];
    endtask

    task automatic load(input int a, input logic [15:0] d);
        drive_load(1'b1, a, d);
        @(posedge clk); #1;
        load_en = 1'b0;
        tab[a] = d;
    endtask

    task automatic run(input int nreq, input bit ld, input int la,
                       input logic [15:0] ld_d, input int inj_cyc,
                       input int rst_cyc, input int lit_err,
                       input int lit_ep, input int lit_conv,
                       input int lit_done);
        logic [15:0] ep_q[$];
        logic [15:0] pv;
        int n, errs, ne, len;
        if (ld) tab[la] = ld_d;
        n = (nreq == 0 || nreq > 8) ? 8 : nreq;
        errs = 0;
        for (int i = 0; i < n; i++)
            errs += (tie1 ? 1'b1 : pred(tab[i])) != tab[i][0];
        ne = (errs == 0) ? 1 : 16;
        for (int e = 0; e < ne; e++) begin
            for (int i = 0; i < n; i++) begin
                ep_q.push_back(tab[i]);
                ep_q.push_back(tab[i]);
            end
            ep_q.push_back(16'h0);
        end
        ep_q.push_back(16'h0);
        len = ep_q.size();
        ep_q.push_back(16'h0);
        if (lit_done >= 0) chk("done_cycle_lit", len, lit_done);

        num_samples = 4'(nreq);
        start = 1'b1;
        drive_load(ld, la, ld_d);
        @(posedge clk); #1;
        start = 1'b0;
        load_en = 1'b0;

        for (int c = 1; c <= len + 1; c++) begin
            if (c == inj_cyc) begin
                drive_load(1'b1, 0, ent(4, 4, 5, 1));
                start = 1'b1;
            end else if (c == inj_cyc + 1) begin
                load_en = 1'b0;
                start = 1'b0;
            end
            if (c == rst_cyc) begin
                reset = 1'b0;
                #1;
                for (int i = 0; i < 8; i++) tab[i] = 16'h0;
                pv = {pbus.p_in1, pbus.p_in2, pbus.p_in3, pbus.p_desired};
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_epoch", epoch_count, 0);
                chk("rst_err", err_count, 0);
                chk("rst_conv", converged, 0);
                chk("rst_p", pv, 0);
                reset = 1'b1;
                @(posedge clk); #1;
                chk("rst_done_after", done, 0);
                chk("rst_busy_after", busy, 0);
                return;
            end
            pv = {pbus.p_in1, pbus.p_in2, pbus.p_in3, pbus.p_desired};
            chk($sformatf("p_drive c%0d", c), pv, ep_q[c-1]);
            chk($sformatf("busy c%0d", c), busy, c < len);
            chk($sformatf("done c%0d", c), done, c == len);
            if (c == len) begin
                chk("epoch_count", epoch_count, ne);
                chk("err_count", err_count, errs);
                chk("converged", converged, errs == 0);
                if (lit_err >= 0) chk("err_lit", err_count, lit_err);
                if (lit_ep >= 0) chk("epoch_lit", epoch_count, lit_ep);
                if (lit_conv >= 0) chk("conv_lit", converged, lit_conv);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tab[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_epoch", epoch_count, 0);
        chk("reset_err", err_count, 0);
        chk("reset_p", {pbus.p_in1, pbus.p_in2, pbus.p_in3, pbus.p_desired}, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Converging: entry1 written in the same cycle as start.
        load(0, ent(4, 4, 5, 1));
        run(2, 1'b1, 1, ent(1, 1, 1, 0), -1, -1, 0, 1, 1, 6);

        // Non-converging, with load/start attempts while busy.
        load(0, ent(1, 1, 1, 1));
        run(1, 1'b0, 0, 16'h0, 10, -1, 1, 16, 0, 49);

        // Stub perceptron stuck at 1, eight alternating labels, N clamped.
        tie1 = 1'b1;
        for (int i = 0; i < 8; i++) load(i, ent(i, 15 - i, i * 9, i % 2));
        run(0, 1'b0, 0, 16'h0, -1, -1, 4, 16, 0, 273);

        // Reset during epoch 3, then readback with a cleared table.
        run(0, 1'b0, 0, 16'h0, -1, 39, -1, -1, -1, -1);
        run(0, 1'b0, 0, 16'h0, -1, -1, 8, 16, 0, 273);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perceptron_trainer.md
Name: perceptron_trainer

Overview:
Training-sequencer for the perceptron block. It stores a small table of labelled samples and drives them onto the perceptron's in1/in2/in3/desired_out inputs. It samples the perceptron's registered decision and counts misclassifications per epoch. Epochs repeat until one completes with zero errors (converged) or until MAX_EPOCHS is reached.

Parameters:
NUM_SAMPLES, 8, sample table depth.
ADDR_W, 3, table address width; NUM_SAMPLES = 2**ADDR_W.
MAX_EPOCHS, 16, epoch limit before giving up; range 1..255.
EPOCH_W, 8, width of epoch_count.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
load_en  in  1  write one table entry this cycle; ignored while busy=1.
load_addr  in  ADDR_W  table entry index.
load_in1  in  4  sample feature 1.
load_in2  in  4  sample feature 2.
load_in3  in  7  sample feature 3.
load_desired  in  1  sample label.
num_samples  in  ADDR_W+1  active entries 0..num_samples-1; sampled at start; 0 or >NUM_SAMPLES clamps to NUM_SAMPLES.
start  in  1  begin training; ignored while busy=1.
p_in1  out  4  to perceptron in1.
p_in2  out  4  to perceptron in2.
p_in3  out  7  to perceptron in3.
p_desired  out  1  to perceptron desired_out.
p_out  in  1  perceptron out (registered, 1-cycle latency).
busy  out  1  training in progress.
done  out  1  one-cycle pulse at end of run.
converged  out  1  last run ended with a zero-error epoch; held until next start.
epoch_count  out  EPOCH_W  epochs completed in current/last run.
err_count  out  ADDR_W+1  mismatches in last completed epoch.

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0; table cleared to zero; idx, err_acc cleared.
- Table write: on the clk edge with load_en=1 and busy=0, store {in1,in2,in3,desired} at load_addr. load_en and start in the same cycle: the write completes and the run uses the new entry.
- FSM states: IDLE, PRESENT, CHECK, EPOCH_END, FINISH.
- IDLE: p_* = 0, so the perceptron sees zero inputs and its weights do not change. When start=1: latch clamped num_samples, set idx=0, err_acc=0, epoch_count=0, converged=0, busy=1; next state PRESENT.
- PRESENT (1 cycle): p_* = table[idx]. The perceptron registers out at the end of this cycle.
- CHECK (1 cycle): p_* still = table[idx], so the perceptron's weight update this edge uses the matching label. err_acc += (p_out != table[idx].desired).
  - If idx = N-1, next state is EPOCH_END.
  - Otherwise idx++ and next state is PRESENT.
- EPOCH_END (1 cycle): p_* = 0; epoch_count++; err_count <= final err_acc, including the last CHECK. Transitions:
  - final err_acc = 0: converged=1, next state FINISH.
  - new epoch_count = MAX_EPOCHS: converged=0, next state FINISH.
  - otherwise: err_acc=0, idx=0, next state PRESENT.
- FINISH (1 cycle): done=1, busy=0, p_*=0; next state IDLE. epoch_count, err_count and converged hold until the next start.
- Timing: one epoch = 2N+1 cycles. Start at edge k: the first PRESENT is cycle k+1; done asserts in cycle k+E*(2N+1)+1 for E epochs.
- err_acc saturates at 2**(ADDR_W+1)-1; it cannot overflow for legal N.
- Reset mid-run: immediate return to IDLE with all state and the table cleared; done is not pulsed.
- start while busy and load_en while busy are ignored with no side effects.

Test Plan:
- Converging run:
  - Stimulus: perceptron at reset weights (10,15,30), threshold 200. Load entry0=(4,4,5,d=1) (sum 250) and entry1=(1,1,1,d=0) (sum 55). num_samples=2, start.
  - Required: one epoch; err_count=0, converged=1, epoch_count=1; done exactly 6 cycles after the start edge.
- Non-converging run:
  - Stimulus: load entry0=(1,1,1,d=1). The perceptron outputs 0 and its learning increment truncates to 0. num_samples=1, start.
  - Required: 16 epochs; err_count=1, converged=0, epoch_count=16; done at cycle 16*3+1 after start.
- Stub perceptron (p_out tied to 1):
  - Stimulus: 8 entries with d alternating 0/1, num_samples=0.
  - Required: N clamps to 8; err_count=4 every epoch; 16 epochs; converged=0.
- Drive check:
  - Stimulus: any run.
  - Required: p_* equals table[idx] in both PRESENT and CHECK of each sample, and is 0 in IDLE, EPOCH_END and FINISH.
- Busy protection:
  - Stimulus: load_en=1 and start=1 asserted mid-run.
  - Required: table unchanged; run unaffected.
- Reset mid-run:
  - Stimulus: reset pulsed low during epoch 3.
  - Required: busy=0, done=0, epoch_count=0, err_count=0, converged=0, p_*=0, and a table readback via the next run shows all zeros.
